// File: rtl/omux_arbiter.sv
// Round-robin arbiter multiplexing byte packets from several sources onto the host output stream,
// with an optional source-tag header byte and a watchdog that aborts stalled packets.
//
// state | meaning
// IDLE  | no packet in flight; arbitrate among requesting sources
// HDR   | presenting the tag header byte for the granted source
// DATA  | forwarding bytes of the granted source until its last byte is consumed
module omux_arbiter #(
  parameter int         SRC_COUNT = 2,
  parameter int         HEADER    = 1,
  parameter logic [3:0] HDR_TAG   = 4'hA,
  parameter int         TIMEOUT   = 1023
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [SRC_COUNT-1:0]   src_req_i,
  input  logic [8*SRC_COUNT-1:0] src_data_i,
  input  logic [SRC_COUNT-1:0]   src_last_i,
  output logic [SRC_COUNT-1:0]   src_ack_o,
  output logic [7:0]             omux_data_o,
  output logic                   omux_req_o,
  input  logic                   omux_sel_i,
  output logic [3:0]             grant_o,
  output logic                   busy_o,
  output logic                   abort_o
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t          state_q;
  logic [3:0]      grant_q;
  logic [3:0]      last_grant_q;
  logic [WD_W-1:0] wd_q;
  logic            abort_q;

  logic [3:0] pick;
  logic       found;
  logic       cur_req;
  logic       cur_last;
  logic [7:0] cur_data;
  logic       ack;
  logic       wd_hit;

  always_comb begin
    cur_req  = 1'b0;
    cur_last = 1'b0;
    cur_data = 8'h00;
    for (int i = 0; i < SRC_COUNT; i++) begin
      if (grant_q == 4'(i)) begin
        cur_req  = src_req_i[i];
        cur_last = src_last_i[i];
        cur_data = src_data_i[8*i +: 8];
      end
    end
  end

  // Scan last_grant+1, +2, ... so the previous winner is considered last.
  always_comb begin
    pick  = last_grant_q;
    found = 1'b0;
    for (int k = 1; k <= SRC_COUNT; k++) begin
      for (int i = 0; i < SRC_COUNT; i++) begin
        if (!found && src_req_i[i] && (i == ((int'(last_grant_q) + k) % SRC_COUNT))) begin
          found = 1'b1;
          pick  = 4'(i);
        end
      end
    end
  end

  assign ack    = (state_q == DATA) && omux_sel_i && cur_req;
  assign wd_hit = (TIMEOUT != 0) && (state_q == DATA) && !cur_req && (wd_q == WD_LAST);

  always_comb begin
    src_ack_o = '0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      src_ack_o[i] = ack && (grant_q == 4'(i));
    end
  end

  always_comb begin
    omux_req_o  = 1'b0;
    omux_data_o = 8'h00;
    if (state_q == HDR) begin
      omux_req_o  = 1'b1;
      omux_data_o = {HDR_TAG, grant_q};
    end else if (state_q == DATA && cur_req) begin
      omux_req_o  = 1'b1;
      omux_data_o = cur_data;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);
  assign abort_o = abort_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      grant_q      <= 4'h0;
      last_grant_q <= 4'(SRC_COUNT - 1);
      wd_q         <= '0;
      abort_q      <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (|src_req_i) begin
            grant_q <= pick;
            state_q <= (HEADER != 0) ? HDR : DATA;
          end
        end
        HDR: begin
          wd_q <= '0;
          if (omux_sel_i) state_q <= DATA;
        end
        DATA: begin
          if (ack) begin
            wd_q <= '0;
            if (cur_last) begin
              state_q      <= IDLE;
              last_grant_q <= grant_q;
            end
          end else if (!cur_req) begin
            if (wd_hit) begin
              state_q      <= IDLE;
              last_grant_q <= grant_q;
              abort_q      <= 1'b1;
              wd_q         <= '0;
            end else if (TIMEOUT != 0) begin
              wd_q <= wd_q + WD_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_omux_arbiter.sv
// Directed bench for omux_arbiter: a 2-source header/watchdog instance and a 3-source headerless one.
module tb_omux_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req, last, ack;
  logic [15:0] data;
  logic        sel;
  logic [7:0]  odata;
  logic        oreq;
  logic [3:0]  grant;
  logic        busy, abort;

  logic [2:0]  b_req, b_last, b_ack;
  logic [23:0] b_data;
  logic        b_sel;
  logic [7:0]  b_odata;
  logic        b_oreq;
  logic [3:0]  b_grant;
  logic        b_busy, b_abort;

  int passed = 0;
  int total  = 0;

  omux_arbiter #(.SRC_COUNT(2), .HEADER(1), .HDR_TAG(4'hA), .TIMEOUT(8)) dut (
    .clk_i(clk), .reset_i(reset), .src_req_i(req), .src_data_i(data), .src_last_i(last),
    .src_ack_o(ack), .omux_data_o(odata), .omux_req_o(oreq), .omux_sel_i(sel),
    .grant_o(grant), .busy_o(busy), .abort_o(abort));

  omux_arbiter #(.SRC_COUNT(3), .HEADER(0), .HDR_TAG(4'hA), .TIMEOUT(8)) dut3 (
    .clk_i(clk), .reset_i(reset), .src_req_i(b_req), .src_data_i(b_data), .src_last_i(b_last),
    .src_ack_o(b_ack), .omux_data_o(b_odata), .omux_req_o(b_oreq), .omux_sel_i(b_sel),
    .grant_o(b_grant), .busy_o(b_busy), .abort_o(b_abort));

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; data = '0; last = '0; sel = 1'b0;
    b_req = '0; b_data = '0; b_last = '0; b_sel = 1'b0;
    @(negedge clk);
    #1;
    total++; if (oreq !== 1'b0) $display("FAIL reset_oreq: got %b want 0", oreq); else passed++;
    total++; if (odata !== 8'h00) $display("FAIL reset_data: got %h want 00", odata); else passed++;
    total++; if (ack !== 2'b00) $display("FAIL reset_ack: got %b want 00", ack); else passed++;
    total++; if (grant !== 4'h0) $display("FAIL reset_grant: got %h want 0", grant); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (abort !== 1'b0) $display("FAIL reset_abort: got %b want 0", abort); else passed++;
    total++; if ({b_oreq, b_busy, b_grant} !== 6'b0) $display("FAIL reset_dut3: got %b want 000000", {b_oreq, b_busy, b_grant}); else passed++;
  endtask

  task automatic test_single();
    logic [7:0]  db [6] = '{8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [11:0] ex [6] = '{{1'b0, 8'h00, 2'b00, 1'b0}, {1'b1, 8'hA0, 2'b00, 1'b1},
                            {1'b1, 8'h11, 2'b01, 1'b1}, {1'b1, 8'h22, 2'b01, 1'b1},
                            {1'b1, 8'h33, 2'b01, 1'b1}, {1'b0, 8'h00, 2'b00, 1'b0}};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      reset = 1'b0; sel = 1'b1;
      req  = (c < 5) ? 2'b01 : 2'b00;
      last = (c == 4) ? 2'b01 : 2'b00;
      data = {8'h00, db[c]};
      #1;
      total++;
      if ({oreq, odata, ack, busy} !== ex[c])
        $display("FAIL single[%0d]: got %h want %h", c, {oreq, odata, ack, busy}, ex[c]);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_b [12] = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h81, 8'h82,
                               8'hA0, 8'h03, 8'h04, 8'hA1, 8'h83, 8'h84};
    logic [3:0] exp_g [12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    logic [7:0] got_b [16];
    logic [3:0] got_g [16];
    int p0 = 0, p1 = 0, n = 0;
    @(negedge clk);
    reset = 1'b1; req = '0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      reset = 1'b0; sel = 1'b1;
      req  = {p1 < 4, p0 < 4};
      last = {p1 % 2 == 1, p0 % 2 == 1};
      data = {8'h81 + 8'(p1), 8'h01 + 8'(p0)};
      #1;
      if (oreq && n < 16) begin
        got_b[n] = odata; got_g[n] = grant; n++;
      end
      if (ack[0]) p0++;
      if (ack[1]) p1++;
    end
    total++; if (n !== 12) $display("FAIL rr_count: got %0d want 12", n); else passed++;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (i >= n || {got_g[i], got_b[i]} !== {exp_g[i], exp_b[i]})
        $display("FAIL rr_byte[%0d]: got %h want %h", i, (i < n) ? {got_g[i], got_b[i]} : 12'hfff, {exp_g[i], exp_b[i]});
      else passed++;
    end
  endtask

  task automatic test_sel_throttle();
    logic [7:0] exp_b [5] = '{8'hA0, 8'h51, 8'h52, 8'h53, 8'h54};
    int p = 0, n = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      sel  = (c % 3 == 2);
      req  = {1'b0, p < 4};
      last = {1'b0, p == 3};
      data = {8'h00, 8'h51 + 8'(p)};
      #1;
      if (!sel) begin
        total++; if (ack !== 2'b00) $display("FAIL throttle_ack[%0d]: got %b want 00", c, ack); else passed++;
      end
      if (oreq) begin
        total++;
        if (n >= 5 || odata !== exp_b[n])
          $display("FAIL throttle_data[%0d]: got %h want %h", c, odata, (n < 5) ? exp_b[n] : 8'hxx);
        else passed++;
        if (sel) n++;
      end
      if (ack[0]) p++;
    end
    total++; if (n !== 5) $display("FAIL throttle_count: got %0d want 5", n); else passed++;
    total++; if (p !== 4) $display("FAIL throttle_acks: got %0d want 4", p); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL throttle_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_watchdog();
    logic [16:0] ex;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      sel = 1'b1;
      if (c < 3) begin
        req = 2'b10; data = {8'hC1, 8'h00}; last = 2'b00;
      end else if (c < 14) begin
        req = 2'b01; data = {8'h00, 8'h77}; last = 2'b01;
      end else begin
        req = 2'b00; data = 16'h0; last = 2'b00;
      end
      if (c == 0)       ex = {1'b0, 8'h00, 2'b00, 4'h0, 1'b0, 1'b0};
      else if (c == 1)  ex = {1'b1, 8'hA1, 2'b00, 4'h1, 1'b1, 1'b0};
      else if (c == 2)  ex = {1'b1, 8'hC1, 2'b10, 4'h1, 1'b1, 1'b0};
      else if (c < 11)  ex = {1'b0, 8'h00, 2'b00, 4'h1, 1'b1, 1'b0};
      else if (c == 11) ex = {1'b0, 8'h00, 2'b00, 4'h1, 1'b0, 1'b1};
      else if (c == 12) ex = {1'b1, 8'hA0, 2'b00, 4'h0, 1'b1, 1'b0};
      else if (c == 13) ex = {1'b1, 8'h77, 2'b01, 4'h0, 1'b1, 1'b0};
      else              ex = {1'b0, 8'h00, 2'b00, 4'h0, 1'b0, 1'b0};
      #1;
      total++;
      if ({oreq, odata, ack, grant, busy, abort} !== ex)
        $display("FAIL watchdog[%0d]: got %h want %h", c, {oreq, odata, ack, grant, busy, abort}, ex);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] ex;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      sel   = 1'b1;
      reset = (c == 3);
      last  = 2'b00;
      if (c < 3)       begin req = 2'b10; data = {8'hD1, 8'h00}; end
      else if (c == 3) begin req = 2'b10; data = {8'hD2, 8'h00}; end
      else             begin req = 2'b11; data = {8'hD2, 8'hE0}; end
      if (c == 0)      ex = {1'b0, 8'h00, 2'b00, 4'h0, 1'b0, 1'b0};
      else if (c == 1) ex = {1'b1, 8'hA1, 2'b00, 4'h1, 1'b1, 1'b0};
      else if (c == 2) ex = {1'b1, 8'hD1, 2'b10, 4'h1, 1'b1, 1'b0};
      else if (c == 3) ex = {1'b1, 8'hD2, 2'b10, 4'h1, 1'b1, 1'b0};
      else if (c == 4) ex = {1'b0, 8'h00, 2'b00, 4'h0, 1'b0, 1'b0};
      else             ex = {1'b1, 8'hA0, 2'b00, 4'h0, 1'b1, 1'b0};
      #1;
      total++;
      if ({oreq, odata, ack, grant, busy, abort} !== ex)
        $display("FAIL reset_mid[%0d]: got %h want %h", c, {oreq, odata, ack, grant, busy, abort}, ex);
      else passed++;
    end
    @(negedge clk);
    reset = 1'b1; req = '0; data = '0; last = '0;
  endtask

  task automatic test_no_header();
    logic [16:0] ex;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      reset = 1'b0; b_sel = 1'b1;
      b_req  = (c < 2) ? 3'b100 : 3'b000;
      b_last = (c < 2) ? 3'b100 : 3'b000;
      b_data = (c < 2) ? {8'h5A, 8'h00, 8'h00} : 24'h0;
      if (c == 0)      ex = {1'b0, 8'h00, 3'b000, 4'h0, 1'b0};
      else if (c == 1) ex = {1'b1, 8'h5A, 3'b100, 4'h2, 1'b1};
      else             ex = {1'b0, 8'h00, 3'b000, 4'h2, 1'b0};
      #1;
      total++;
      if ({b_oreq, b_odata, b_ack, b_grant, b_busy} !== ex)
        $display("FAIL no_header[%0d]: got %h want %h", c, {b_oreq, b_odata, b_ack, b_grant, b_busy}, ex);
      else passed++;
    end
    total++; if (b_abort !== 1'b0) $display("FAIL no_header_abort: got %b want 0", b_abort); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_sel_throttle();
    test_watchdog();
    test_reset_mid();
    test_no_header();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
